// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Holds the PC, issues word fetches over a req/gnt + rvalid memory port,
// buffers returned words with their PCs in a DEPTH-entry in-order queue and
// hands them to decode. Redirects flush the queue and arrange for every live
// outstanding response to be discarded on arrival.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr        fetch request and address (current PC)
//   i_imem_gnt                     request accepted this cycle
//   i_imem_rvalid, i_imem_rdata    in-order response word
//   i_redirect, i_redirect_pc      redirect request and target
//   o_valid, o_opcode, o_pc        queue head presented to decode
//   i_ready                        decode accepts the head this cycle
//   o_fetch_fault, o_fault_pc      misaligned redirect target pending
//   o_dbg_state                    current FSM state (IDLE=0, RUN=1, FAULT=2)
//
// Handshakes: a memory request is accepted on a cycle where o_imem_req and
// i_imem_gnt are both high; once raised, o_imem_req/o_imem_addr hold until
// that cycle, and only a redirect may drop the request. A decode transfer
// happens on a cycle where o_valid and i_ready are both high; o_opcode/o_pc
// hold while o_valid is high and i_ready is low.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic        o_fetch_fault,
  output logic [31:0] o_fault_pc,
  output logic [1:0]  o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   pc, resp_pc, fault_pc;
  logic [CW-1:0] count, inflight, kill;
  logic [CW-1:0] count_nxt, inflight_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   op_mem [DEPTH];

  logic redirect_act, misaligned, accept, push, pop;
  logic [CW:0] occupancy;

  // Redirects are ignored while still coming out of reset.
  assign redirect_act = i_redirect && (state != S_IDLE);
  assign misaligned   = |i_redirect_pc[1:0];

  // Credit rule: every outstanding request and every queued word holds a
  // slot, so a returning word always has room. A same-cycle pop earns no
  // credit, which keeps req a function of registered state plus redirect.
  assign occupancy  = {1'b0, inflight} + {1'b0, count};
  assign o_imem_req = (state == S_RUN) && !i_redirect && (occupancy < DEPTH_W);
  assign o_imem_addr = pc;

  assign accept = o_imem_req && i_imem_gnt;
  // Words arriving while kill is nonzero belong to a flushed stream.
  assign push   = i_imem_rvalid && (kill == '0) && !redirect_act;
  assign pop    = o_valid && i_ready && !redirect_act;

  assign o_valid       = (count != '0);
  assign o_opcode      = op_mem[rd_ptr];
  assign o_pc          = pc_mem[rd_ptr];
  assign o_fetch_fault = (state == S_FAULT);
  assign o_fault_pc    = fault_pc;
  assign o_dbg_state   = state;

  // FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_RUN;
      S_RUN:   if (i_redirect && misaligned)  state_nxt = S_FAULT;
      S_FAULT: if (i_redirect && !misaligned) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter next values outside of a redirect.
  always_comb begin
    inflight_nxt = inflight;
    if (accept && !i_imem_rvalid)      inflight_nxt = inflight + ONE;
    else if (!accept && i_imem_rvalid) inflight_nxt = inflight - ONE;

    count_nxt = count;
    if (push && !pop)      count_nxt = count + ONE;
    else if (!push && pop) count_nxt = count - ONE;
  end

  // Control and pointer state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      fault_pc <= 32'h0;
      count    <= '0;
      inflight <= '0;
      kill     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_act) begin
      pc      <= i_redirect_pc;
      resp_pc <= i_redirect_pc;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      // No request goes out on a redirect cycle, so only a response can
      // change the outstanding total; everything still outstanding is stale.
      inflight <= i_imem_rvalid ? (inflight - ONE) : inflight;
      kill     <= i_imem_rvalid ? (inflight - ONE) : inflight;
      if (misaligned) fault_pc <= i_redirect_pc;
    end else begin
      if (accept) pc <= pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (i_imem_rvalid && (kill != '0)) kill <= kill - ONE;
      count    <= count_nxt;
      inflight <= inflight_nxt;
    end
  end

  // Queue storage; contents are only observed while o_valid is high.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= resp_pc;
      op_mem[wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
//
// Reference model: the instruction stream seen by decode is the run of
// consecutive word addresses starting at the last redirect target (or the
// reset PC), each paired with the memory word at that address. Every accepted
// fetch pushes its expected {pc, opcode} onto exp_q; a redirect clears it.
// The monitor pops exp_q when decode takes a word. The memory responder keeps
// a list of outstanding fetches, each tagged stale once a redirect passes it.

module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] opcode;
  logic [31:0] pc;
  logic        ready;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .o_opcode      (opcode),
    .o_pc          (pc),
    .i_ready       (ready),
    .o_fetch_fault (fetch_fault),
    .o_fault_pc    (fault_pc),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          mode;          // 0 idle, 1 running, 2 faulted
  logic [31:0] model_pc;
  int          buffered;      // live words sitting in the DUT queue
  logic [31:0] model_fault_pc;
  logic [31:0] pend_addr[$];  // outstanding fetches, oldest first
  bit          pend_stale[$];
  logic [63:0] exp_q[$];      // {pc, opcode} still owed to decode

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode           = 0;
    model_pc       = RESET_PC;
    buffered       = 0;
    model_fault_pc = 32'h0;
    pend_addr.delete();
    pend_stale.delete();
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic exp_req;
    logic [63:0] head;
    if (!rst_n) begin
      check32("reset_req", 32'(imem_req), 32'd0);
      check32("reset_valid", 32'(valid), 32'd0);
      check32("reset_fault", 32'(fetch_fault), 32'd0);
      check32("reset_fault_pc", fault_pc, 32'h0);
      model_reset();
    end else begin
      exp_req = (mode == 1) && !redirect && ((pend_addr.size() + buffered) < DEPTH);
      check32("req", 32'(imem_req), 32'(exp_req));
      if (imem_req && exp_req) check32("addr", imem_addr, model_pc);
      check32("valid", 32'(valid), 32'(buffered != 0));
      if (valid && buffered != 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL head: DUT valid but no expected word queued (t=%0t)", $time);
        end else begin
          head = exp_q[0];
          check32("head_pc", pc, head[63:32]);
          check32("head_opcode", opcode, head[31:0]);
        end
      end
      check32("fault", 32'(fetch_fault), 32'(mode == 2));
      check32("fault_pc", fault_pc, model_fault_pc);

      // Predict the effect of the coming rising edge.
      if (mode == 0) begin
        mode = 1;
      end else if (redirect) begin
        foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        if (imem_rvalid && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_stale.pop_front());
        end
        exp_q.delete();
        buffered = 0;
        model_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
          mode           = 2;
          model_fault_pc = redirect_pc;
        end else begin
          mode = 1;
        end
      end else begin
        if (imem_req && imem_gnt) begin
          pend_addr.push_back(model_pc);
          pend_stale.push_back(1'b0);
          exp_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
        if (imem_rvalid && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          if (!pend_stale.pop_front()) buffered++;
        end
        if (valid && ready && buffered > 0) begin
          void'(exp_q.pop_front());
          buffered--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; percentages set grant, response and ready rates.
  task automatic drive_cycle(input int gnt_pct, input int rv_pct, input int rdy_pct,
                             input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    ready       = ($urandom_range(0, 99) < rdy_pct);
    redirect    = redir;
    redirect_pc = redir ? tgt : $urandom;
    if (rst_n && pend_addr.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic run(input int n, input int gnt_pct, input int rv_pct, input int rdy_pct);
    for (int i = 0; i < n; i++) drive_cycle(gnt_pct, rv_pct, rdy_pct, 1'b0, 32'h0);
  endtask

  task automatic random_run(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 99) < 20) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 5) tgt = 32'hFFFF_FFF0;
      drive_cycle($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                  ($urandom_range(0, 99) < 3), tgt);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(20, 100, 100, 100);            // full-rate streaming
    run(15, 100, 100, 0);              // decode stalled: queue fills, req drops
    run(10, 100, 100, 100);            // drain in order, req resumes
    run(5, 0, 100, 100);               // grant withheld: req/addr must hold

    run(4, 100, 0, 0);                 // fill credit with no responses
    run(1, 0, 100, 0);                 // one word queued, one still in flight
    drive_cycle(100, 0, 100, 1'b1, 32'h0000_0100);
    run(12, 100, 100, 100);

    drive_cycle(100, 100, 100, 1'b1, 32'h0000_0102);  // misaligned target
    run(6, 100, 100, 100);
    drive_cycle(100, 100, 100, 1'b1, 32'h0000_0200);  // clears fault
    run(10, 100, 100, 100);

    drive_cycle(100, 100, 100, 1'b1, 32'hFFFF_FFF8);  // PC wraps past top
    run(8, 100, 100, 100);

    random_run(2000);

    // Reset in the middle of traffic.
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(10, 100, 100, 100);
    random_run(300);
    run(20, 100, 100, 100);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
